mono_raster_scanner: RTL and testbench
======================================

// Module: mono_raster_scanner
// PURPOSE
//  Parametrised 1-bpp raster output engine for CRT-style mono displays (Mac 512x342 by default).
//  Generates hsync/vsync/video from programmable timing and prefetches packed pixel words
//  from a framebuffer over a request/valid handshake, double-buffered (holding reg + shifter).
//  Adds linear addressing, underrun detection, frame strobe, and sync/video polarity control.
// PARAMETERS
//  ACTIVE_WIDTH    512  active pixels per line; multiple of WORD_BITS
//  ACTIVE_HEIGHT   342  active lines per frame
//  ACTIVE_XOFFSET  192  first active xscan; must be >= WORD_BITS
//  ACTIVE_YOFFSET  48   first active yscan
//  TOTAL_WIDTH     720  clocks per line
//  TOTAL_HEIGHT    391  lines per frame
//  HSYNC_OFFSET    294  hsync active for xscan in [0,HSYNC_OFFSET)
//  VSYNC_OFFSET    128  xscan at which vsync changes state
//  VSYNC_LINES     6    vsync active from (y=0,x=VSYNC_OFFSET) to (y=VSYNC_LINES,x=VSYNC_OFFSET)
//  WORD_BITS       16   pixels per fetched word, MSB shown first
//  ADDR_BITS       14   fetch address width
//  SYNC_ACTIVE     0    logic level of asserted hsync/vsync
//  INVERT          1    out = fb bit XOR INVERT in active window
//  IDLE_LEVEL      1    out level outside active window and during underrun
// PORTS
//  clk          in   1          pixel clock
//  reset        in   1          synchronous, active-high
//  fetch_req    out  1          one-cycle pulse: request word at fetch_addr
//  fetch_addr   out  ADDR_BITS  linear word address, valid while fetch_req high
//  fetch_data   in   WORD_BITS  returned pixel word
//  fetch_valid  in   1          fetch_data valid this cycle
//  hsync        out  1          horizontal sync
//  vsync        out  1          vertical sync
//  out          out  1          video bit
//  frame_start  out  1          one-cycle pulse when xscan=0,yscan=0
//  underrun     out  1          sticky: a word was needed but not yet returned; cleared at frame_start
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset: xscan=yscan=0, hsync=vsync=!SYNC_ACTIVE,
//    out=IDLE_LEVEL, fetch_req=0, fetch_addr=0, frame_start=0, underrun=0, holding/shifter invalid.
//  - xscan wraps TOTAL_WIDTH-1 -> 0 and increments yscan; yscan wraps TOTAL_HEIGHT-1 -> 0.
//  - hsync, vsync, out registered: all lag xscan by exactly 1 clock, mutually aligned.
//  - Active window: XOFF <= xscan < XOFF+W and YOFF <= yscan < YOFF+H.
//  - Prefetch: on active lines, fetch_req at xscan = XOFF-WORD_BITS (word 0), then at each
//    word boundary xscan = XOFF+k*WORD_BITS while k+1 < W/WORD_BITS (32 requests/line default).
//  - fetch_addr = line*(W/WORD_BITS)+word, kept as an incremental counter (no multiplier);
//    reset to 0 at frame_start; continues across lines (line 1 word 0 = 32 by default).
//  - Memory must assert fetch_valid within WORD_BITS-1 clocks of fetch_req; data captured into
//    holding reg. fetch_valid with no request outstanding is ignored.
//  - At each word boundary the shifter loads from holding; the pixel that cycle is holding MSB,
//    afterwards shifter MSB, shifting left one per clock.
//  - Underrun: holding not valid at boundary -> that whole word outputs IDLE_LEVEL, underrun set;
//    next fetch still issued. underrun clears on frame_start unless set again in the same cycle.
//  - Reset mid-line: outstanding request abandoned; any later fetch_valid ignored.
// STRUCTURE
//  - Shared include raster_defs.vh: Mac default timing constants, log2 helper macro.
//  - Sub-module raster_timing: xscan/yscan counters, hsync/vsync, frame_start, active/boundary
//    flags. Top level holds fetch sequencer, holding reg, shifter, underrun flag, output register.
// TESTING
//  - Reset held 3 clocks -> out=1, hsync=vsync=1, fetch_req=0, underrun=0 on every cycle.
//  - Free run defaults -> hsync low 294 of 720 clocks; vsync low 6*720 clocks; frame = 391*720.
//  - Line YOFF -> first fetch_req at xscan 176 addr 0, last addr 31; next line starts addr 32.
//  - Memory model latency 2, word 16'h8001 -> out (INVERT=1) 0,1x14,0 starting xscan 193.
//  - Withhold fetch_valid for word 5 -> 16 clocks of out=1, underrun=1 until next frame_start.
//  - Small params (W=32,H=4,TW=64,TH=8) reset mid-active-line -> clean restart, addr 0 next frame.

Source files
------------

// File: rtl/mono_raster_scanner_pkg.sv
// Shared timing defaults (Mac 512x342 mono) and small helpers for the raster scanner.
package mono_raster_scanner_pkg;
  localparam int MAC_ACTIVE_WIDTH   = 512;
  localparam int MAC_ACTIVE_HEIGHT  = 342;
  localparam int MAC_ACTIVE_XOFFSET = 192;
  localparam int MAC_ACTIVE_YOFFSET = 48;
  localparam int MAC_TOTAL_WIDTH    = 720;
  localparam int MAC_TOTAL_HEIGHT   = 391;
  localparam int MAC_HSYNC_OFFSET   = 294;
  localparam int MAC_VSYNC_OFFSET   = 128;
  localparam int MAC_VSYNC_LINES    = 6;
  localparam int MAC_WORD_BITS      = 16;
  localparam int MAC_ADDR_BITS      = 14;

  function automatic int words_per_line(input int w, input int wb);
    return w / wb;
  endfunction
endpackage

// File: rtl/mono_raster_scanner_timing.sv
// Beam position counters, registered sync/frame strobes and the combinational
// window / word-boundary / fetch-point decodes used by the fetch path.
module mono_raster_scanner_timing
  import mono_raster_scanner_pkg::*;
#(
  parameter int   ACTIVE_WIDTH   = MAC_ACTIVE_WIDTH,
  parameter int   ACTIVE_HEIGHT  = MAC_ACTIVE_HEIGHT,
  parameter int   ACTIVE_XOFFSET = MAC_ACTIVE_XOFFSET,
  parameter int   ACTIVE_YOFFSET = MAC_ACTIVE_YOFFSET,
  parameter int   TOTAL_WIDTH    = MAC_TOTAL_WIDTH,
  parameter int   TOTAL_HEIGHT   = MAC_TOTAL_HEIGHT,
  parameter int   HSYNC_OFFSET   = MAC_HSYNC_OFFSET,
  parameter int   VSYNC_OFFSET   = MAC_VSYNC_OFFSET,
  parameter int   VSYNC_LINES    = MAC_VSYNC_LINES,
  parameter int   WORD_BITS      = MAC_WORD_BITS,
  parameter logic SYNC_ACTIVE    = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic frame_start_o,
  output logic act_o,
  output logic bnd_o,
  output logic fetch_pt_o,
  output logic fs_now_o
);
  localparam int XW     = $clog2(TOTAL_WIDTH);
  localparam int YW     = $clog2(TOTAL_HEIGHT);
  localparam int NWORDS = words_per_line(ACTIVE_WIDTH, WORD_BITS);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hs_q, vs_q, fs_q;
  logic          line_act, vs_on;
  int            xi, yi;

  assign xi = int'(x_q);
  assign yi = int'(y_q);

  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == XW'(TOTAL_WIDTH - 1)) begin
      x_d = '0;
      y_d = (y_q == YW'(TOTAL_HEIGHT - 1)) ? '0 : y_q + 1'b1;
    end
  end

  assign line_act = (yi >= ACTIVE_YOFFSET) && (yi < ACTIVE_YOFFSET + ACTIVE_HEIGHT);
  assign act_o    = line_act && (xi >= ACTIVE_XOFFSET) && (xi < ACTIVE_XOFFSET + ACTIVE_WIDTH);
  // WORD_BITS is a power of two, so the boundary test is a mask, not a divide.
  assign bnd_o    = act_o && (((xi - ACTIVE_XOFFSET) & (WORD_BITS - 1)) == 0);
  assign fetch_pt_o = line_act && ((xi == ACTIVE_XOFFSET - WORD_BITS) ||
                      (bnd_o && (xi < ACTIVE_XOFFSET + (NWORDS - 1) * WORD_BITS)));
  assign fs_now_o = (x_q == '0) && (y_q == '0);

  // vsync spans (y=0,x=VOFF) up to but excluding (y=VSYNC_LINES,x=VOFF).
  assign vs_on = ((yi == 0) && (xi >= VSYNC_OFFSET)) ||
                 ((yi > 0) && (yi < VSYNC_LINES)) ||
                 ((yi == VSYNC_LINES) && (xi < VSYNC_OFFSET));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~SYNC_ACTIVE;
      vs_q <= ~SYNC_ACTIVE;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= (xi < HSYNC_OFFSET) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_q <= vs_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      fs_q <= fs_now_o;
    end
  end

  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign frame_start_o = fs_q;
endmodule

// File: rtl/mono_raster_scanner.sv
// 1-bpp raster engine: word prefetch sequencer, holding register, pixel shifter,
// sticky underrun flag and the registered video bit.
module mono_raster_scanner
  import mono_raster_scanner_pkg::*;
#(
  parameter int   ACTIVE_WIDTH   = MAC_ACTIVE_WIDTH,
  parameter int   ACTIVE_HEIGHT  = MAC_ACTIVE_HEIGHT,
  parameter int   ACTIVE_XOFFSET = MAC_ACTIVE_XOFFSET,
  parameter int   ACTIVE_YOFFSET = MAC_ACTIVE_YOFFSET,
  parameter int   TOTAL_WIDTH    = MAC_TOTAL_WIDTH,
  parameter int   TOTAL_HEIGHT   = MAC_TOTAL_HEIGHT,
  parameter int   HSYNC_OFFSET   = MAC_HSYNC_OFFSET,
  parameter int   VSYNC_OFFSET   = MAC_VSYNC_OFFSET,
  parameter int   VSYNC_LINES    = MAC_VSYNC_LINES,
  parameter int   WORD_BITS      = MAC_WORD_BITS,
  parameter int   ADDR_BITS      = MAC_ADDR_BITS,
  parameter logic SYNC_ACTIVE    = 1'b0,
  parameter logic INVERT         = 1'b1,
  parameter logic IDLE_LEVEL     = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic                 fetch_req_o,
  output logic [ADDR_BITS-1:0] fetch_addr_o,
  input  logic [WORD_BITS-1:0] fetch_data_i,
  input  logic                 fetch_valid_i,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 out_o,
  output logic                 frame_start_o,
  output logic                 underrun_o
);
  logic                 act, bnd, fetch_pt, fs_now, accept;
  logic [ADDR_BITS-1:0] addr_q, addr_d, addr_base;
  logic [WORD_BITS-1:0] hold_q, hold_d, sh_q, sh_d;
  logic                 pend_q, pend_d, hold_vld_q, hold_vld_d;
  logic                 sh_vld_q, sh_vld_d, urun_q, urun_d, out_q, out_d;

  mono_raster_scanner_timing #(
    .ACTIVE_WIDTH  (ACTIVE_WIDTH),   .ACTIVE_HEIGHT (ACTIVE_HEIGHT),
    .ACTIVE_XOFFSET(ACTIVE_XOFFSET), .ACTIVE_YOFFSET(ACTIVE_YOFFSET),
    .TOTAL_WIDTH   (TOTAL_WIDTH),    .TOTAL_HEIGHT  (TOTAL_HEIGHT),
    .HSYNC_OFFSET  (HSYNC_OFFSET),   .VSYNC_OFFSET  (VSYNC_OFFSET),
    .VSYNC_LINES   (VSYNC_LINES),    .WORD_BITS     (WORD_BITS),
    .SYNC_ACTIVE   (SYNC_ACTIVE)
  ) u_timing (
    .clk_i, .reset_i, .hsync_o, .vsync_o, .frame_start_o,
    .act_o(act), .bnd_o(bnd), .fetch_pt_o(fetch_pt), .fs_now_o(fs_now)
  );

  assign fetch_req_o  = fetch_pt && !reset_i;
  // Address restarts at the top of frame; the frame's first fetch may land on that cycle.
  assign addr_base    = fs_now ? '0 : addr_q;
  assign fetch_addr_o = addr_base;
  assign accept       = fetch_valid_i && (pend_q || fetch_req_o);

  always_comb begin
    addr_d     = addr_base + ADDR_BITS'(fetch_req_o);
    pend_d     = (pend_q || fetch_req_o) && !accept;
    hold_d     = accept ? fetch_data_i : hold_q;
    hold_vld_d = accept || (hold_vld_q && !bnd);
    sh_d       = sh_q << 1;
    sh_vld_d   = sh_vld_q;
    urun_d     = fs_now ? 1'b0 : urun_q;
    out_d      = IDLE_LEVEL;
    if (bnd) begin
      // Holding MSB goes straight to the pixel; the shifter keeps the rest.
      sh_d     = hold_q << 1;
      sh_vld_d = hold_vld_q;
      if (hold_vld_q) out_d  = hold_q[WORD_BITS-1] ^ INVERT;
      else            urun_d = 1'b1;
    end else if (act && sh_vld_q) begin
      out_d = sh_q[WORD_BITS-1] ^ INVERT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q     <= '0;
      pend_q     <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      sh_vld_q   <= 1'b0;
      urun_q     <= 1'b0;
      out_q      <= IDLE_LEVEL;
    end else begin
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      sh_vld_q   <= sh_vld_d;
      urun_q     <= urun_d;
      out_q      <= out_d;
    end
  end

  assign out_o      = out_q;
  assign underrun_o = urun_q;
endmodule

// File: tb/tb_mono_raster_scanner.sv
// Directed bench: default Mac timing instance (A) and a small-geometry instance (B).
module tb_mono_raster_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: default parameters
  logic        rst_a = 1'b1, req_a, vld_a = 1'b0, hs_a, vs_a, out_a, fs_a, ur_a;
  logic [13:0] addr_a;
  logic [15:0] data_a = '0;

  mono_raster_scanner dut_a (
    .clk_i(clk), .reset_i(rst_a), .fetch_req_o(req_a), .fetch_addr_o(addr_a),
    .fetch_data_i(data_a), .fetch_valid_i(vld_a), .hsync_o(hs_a), .vsync_o(vs_a),
    .out_o(out_a), .frame_start_o(fs_a), .underrun_o(ur_a)
  );

  // Instance B: W=32 H=4 XOFF=16 YOFF=2 TW=64 TH=8
  logic        rst_b = 1'b1, req_b, vld_b = 1'b0, hs_b, vs_b, out_b, fs_b, ur_b;
  logic [13:0] addr_b;
  logic [15:0] data_b = '0;

  mono_raster_scanner #(
    .ACTIVE_WIDTH(32), .ACTIVE_HEIGHT(4), .ACTIVE_XOFFSET(16), .ACTIVE_YOFFSET(2),
    .TOTAL_WIDTH(64), .TOTAL_HEIGHT(8), .HSYNC_OFFSET(10), .VSYNC_OFFSET(8),
    .VSYNC_LINES(1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst_b), .fetch_req_o(req_b), .fetch_addr_o(addr_b),
    .fetch_data_i(data_b), .fetch_valid_i(vld_b), .hsync_o(hs_b), .vsync_o(vs_b),
    .out_o(out_b), .frame_start_o(fs_b), .underrun_o(ur_b)
  );

  // Cycle index since reset release; equals xscan + yscan*TOTAL_WIDTH.
  int cyc_a = 0, cyc_b = 0;
  always @(posedge clk) begin
    cyc_a <= rst_a ? 0 : cyc_a + 1;
    cyc_b <= rst_b ? 0 : cyc_b + 1;
  end

  function automatic logic [15:0] mem_b(input int a);
    return 16'hA5C3 ^ 16'(a);
  endfunction

  // Memory models, latency 2; B can withhold one address.
  int          cnt_a = 0, cnt_b = 0, drop_b = -1;
  logic [13:0] ma_b = '0;
  always @(posedge clk) begin
    #1;
    vld_a = 1'b0;
    if (cnt_a > 0) begin
      cnt_a--;
      if (cnt_a == 0) begin vld_a = 1'b1; data_a = 16'h8001; end
    end
    if (req_a === 1'b1) cnt_a = 2;
    vld_b = 1'b0;
    if (cnt_b > 0) begin
      cnt_b--;
      if (cnt_b == 0 && int'(ma_b) != drop_b) begin vld_b = 1'b1; data_b = mem_b(int'(ma_b)); end
    end
    if (req_b === 1'b1) begin cnt_b = 2; ma_b = addr_b; end
  end

  task automatic wait_cyc(input bit sel_b, input int t);
    int cur;
    cur = sel_b ? cyc_b : cyc_a;
    if (cur > t) begin
      total++; bad++;
      $display("FAIL wait_overshoot now=%0d want=%0d", cur, t);
      return;
    end
    for (int g = 0; g < 60000 && cur != t; g++) begin
      @(posedge clk); #1;
      cur = sel_b ? cyc_b : cyc_a;
    end
    if (cur != t) begin
      total++; bad++;
      $display("FAIL wait_timeout now=%0d want=%0d", cur, t);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({out_a, hs_a, vs_a, req_a, ur_a, fs_a} !== 6'b111000)
        $display("FAIL reset_a_outs got=%b exp=111000", {out_a, hs_a, vs_a, req_a, ur_a, fs_a});
      if ({out_a, hs_a, vs_a, req_a, ur_a, fs_a} !== 6'b111000) bad++;
      total++;
      if (addr_a !== 14'd0) begin bad++; $display("FAIL reset_a_addr got=%0d exp=0", addr_a); end
      total++;
      if ({out_b, hs_b, vs_b, req_b, ur_b, fs_b} !== 6'b111000) begin
        bad++; $display("FAIL reset_b_outs got=%b exp=111000", {out_b, hs_b, vs_b, req_b, ur_b, fs_b});
      end
    end
  endtask

  task automatic test_sync();
    int hs_low = 0, vs_low = 0, fs_cnt = 0;
    for (int t = 1; t <= 7 * 720; t++) begin
      @(posedge clk); #1;
      if (t <= 720 && hs_a === 1'b0) hs_low++;
      if (vs_a === 1'b0) vs_low++;
      if (t >= 2 && fs_a === 1'b1) fs_cnt++;
      if (t == 1) begin
        total++; if (hs_a !== 1'b0) begin bad++; $display("FAIL hsync_first got=%b exp=0", hs_a); end
        total++; if (fs_a !== 1'b1) begin bad++; $display("FAIL frame_start got=%b exp=1", fs_a); end
      end
      if (t == 295) begin
        total++; if (hs_a !== 1'b1) begin bad++; $display("FAIL hsync_end got=%b exp=1", hs_a); end
      end
      if (t == 128 || t == 4449) begin
        total++; if (vs_a !== 1'b1) begin bad++; $display("FAIL vsync_off t=%0d got=%b exp=1", t, vs_a); end
      end
      if (t == 129 || t == 4448) begin
        total++; if (vs_a !== 1'b0) begin bad++; $display("FAIL vsync_on t=%0d got=%b exp=0", t, vs_a); end
      end
    end
    total++; if (hs_low != 294)  begin bad++; $display("FAIL hsync_low got=%0d exp=294", hs_low); end
    total++; if (vs_low != 4320) begin bad++; $display("FAIL vsync_low got=%0d exp=4320", vs_low); end
    total++; if (fs_cnt != 0)    begin bad++; $display("FAIL frame_start_extra got=%0d exp=0", fs_cnt); end
  endtask

  task automatic test_fetch_video();
    int   nreq = 0, first_x = -1, last_addr = -1, k;
    logic exp;
    wait_cyc(1'b0, 48 * 720);
    for (int i = 1; i <= 720; i++) begin
      @(posedge clk); #1;
      if (req_a === 1'b1) begin
        if (nreq == 0) first_x = i % 720;
        total++;
        if (addr_a !== 14'(nreq)) begin bad++; $display("FAIL fetch_addr got=%0d exp=%0d", addr_a, nreq); end
        last_addr = int'(addr_a);
        nreq++;
      end
      if ((i >= 192 && i <= 224) || i == 704 || i == 705) begin
        k   = (i - 193) % 16;
        exp = (i == 192 || i == 705) ? 1'b1 : ((k == 0 || k == 15) ? 1'b0 : 1'b1);
        total++;
        if (out_a !== exp) begin bad++; $display("FAIL video_a x=%0d got=%b exp=%b", i - 1, out_a, exp); end
      end
    end
    total++; if (first_x != 176)  begin bad++; $display("FAIL first_fetch_x got=%0d exp=176", first_x); end
    total++; if (nreq != 32)      begin bad++; $display("FAIL fetch_count got=%0d exp=32", nreq); end
    total++; if (last_addr != 31) begin bad++; $display("FAIL last_addr got=%0d exp=31", last_addr); end
    total++; if (ur_a !== 1'b0)   begin bad++; $display("FAIL underrun_a got=%b exp=0", ur_a); end
  endtask

  task automatic test_next_line();
    wait_cyc(1'b0, 49 * 720 + 175);
    total++; if (req_a !== 1'b0) begin bad++; $display("FAIL early_req got=%b exp=0", req_a); end
    wait_cyc(1'b0, 49 * 720 + 176);
    total++; if (req_a !== 1'b1)   begin bad++; $display("FAIL line49_req got=%b exp=1", req_a); end
    total++; if (addr_a !== 14'd32) begin bad++; $display("FAIL line49_addr got=%0d exp=32", addr_a); end
  endtask

  task automatic test_small_frame();
    int          fs_cnt = 0;
    logic [15:0] w;
    for (int t = 1; t <= 513; t++) begin
      @(posedge clk); #1;
      if (t >= 2 && t <= 512 && fs_b === 1'b1) fs_cnt++;
      if (t == 1 || t == 513) begin
        total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL b_frame_start t=%0d got=%b exp=1", t, fs_b); end
      end
      if (t == 128 || t == 144) begin
        total++;
        if (req_b !== 1'b1 || addr_b !== 14'((t - 128) / 16)) begin
          bad++; $display("FAIL b_fetch t=%0d req=%b addr=%0d exp_addr=%0d", t, req_b, addr_b, (t - 128) / 16);
        end
      end
      if (t >= 145 && t <= 176) begin
        w = mem_b((t - 145) / 16);
        total++;
        if (out_b !== (w[15 - (t - 145) % 16] ^ 1'b1)) begin
          bad++; $display("FAIL b_video t=%0d got=%b exp=%b", t, out_b, w[15 - (t - 145) % 16] ^ 1'b1);
        end
      end
    end
    total++; if (fs_cnt != 0)   begin bad++; $display("FAIL b_frame_len extra=%0d exp=0", fs_cnt); end
    total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL b_underrun_clean got=%b exp=0", ur_b); end
  endtask

  task automatic test_underrun();
    logic [15:0] w;
    drop_b = 5;
    w = mem_b(4);
    for (int k = 0; k < 16; k++) begin
      wait_cyc(1'b1, 785 + k);
      total++;
      if (out_b !== (w[15 - k] ^ 1'b1)) begin bad++; $display("FAIL word4_video k=%0d got=%b exp=%b", k, out_b, w[15 - k] ^ 1'b1); end
    end
    total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL underrun_early got=%b exp=0", ur_b); end
    for (int k = 0; k < 16; k++) begin
      wait_cyc(1'b1, 801 + k);
      total++; if (out_b !== 1'b1) begin bad++; $display("FAIL underrun_idle k=%0d got=%b exp=1", k, out_b); end
      total++; if (ur_b !== 1'b1)  begin bad++; $display("FAIL underrun_flag k=%0d got=%b exp=1", k, ur_b); end
    end
    wait_cyc(1'b1, 832);
    total++;
    if (req_b !== 1'b1 || addr_b !== 14'd6) begin bad++; $display("FAIL post_underrun_fetch req=%b addr=%0d exp_addr=6", req_b, addr_b); end
    wait_cyc(1'b1, 1024);
    total++; if (ur_b !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b exp=1", ur_b); end
    drop_b = -1;
    wait_cyc(1'b1, 1025);
    total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b exp=0", ur_b); end
    total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL underrun_fs got=%b exp=1", fs_b); end
  endtask

  task automatic test_reset_midline();
    logic [15:0] w;
    wait_cyc(1'b1, 1024 + 145);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    total++;
    if ({out_b, hs_b, vs_b, req_b, ur_b, fs_b} !== 6'b111000) begin
      bad++; $display("FAIL midline_reset got=%b exp=111000", {out_b, hs_b, vs_b, req_b, ur_b, fs_b});
    end
    wait_cyc(1'b1, 1);
    total++; if (fs_b !== 1'b1) begin bad++; $display("FAIL restart_fs got=%b exp=1", fs_b); end
    wait_cyc(1'b1, 128);
    total++;
    if (req_b !== 1'b1 || addr_b !== 14'd0) begin bad++; $display("FAIL restart_fetch req=%b addr=%0d exp_addr=0", req_b, addr_b); end
    w = mem_b(0);
    for (int k = 0; k < 16; k++) begin
      wait_cyc(1'b1, 145 + k);
      total++;
      if (out_b !== (w[15 - k] ^ 1'b1)) begin bad++; $display("FAIL restart_video k=%0d got=%b exp=%b", k, out_b, w[15 - k] ^ 1'b1); end
    end
    wait_cyc(1'b1, 200);
    total++; if (ur_b !== 1'b0) begin bad++; $display("FAIL restart_underrun got=%b exp=0", ur_b); end
  endtask

  initial begin
    test_reset();
    rst_a = 1'b0;
    test_sync();
    test_fetch_video();
    test_next_line();
    rst_b = 1'b0;
    test_small_frame();
    test_underrun();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
